tile_lane_engine: RTL

//   Parametrised scrolling-tile game core: LANES columns, ROWS visible rows plus one staging row above the screen.

---
 rtl/tile_lane_engine.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/tile_lane_engine.sv
// tile_lane_engine: scrolling-tile game core (lane judging, score, speed ramp, pixel flags); TILES_LIVES_EN adds lives.
// Latency: game state reacts one cycle after the causing input; pix_* are registered one cycle after DrawX/DrawY.
// Backpressure: none; vs edges, start and key strobes are consumed in the cycle they arrive.
module tile_lane_engine #(
  parameter int          LANES           = 5,
  parameter int          ROWS            = 4,
  parameter int          ROW_H           = 120,
  parameter int          LANE_W          = 128,
  parameter int          SPEED_INIT      = 1,
  parameter int          SPEED_INC       = 2,
  parameter int          SPEED_MAX       = 12,
  parameter int          SPEED_STEP_ROWS = 5,
  parameter int          SCORE_W         = 10,
  parameter int          LIVES_INIT      = 3,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  localparam int         LW              = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               pixel_clk,
  input  logic               Reset,
  input  logic               vs,
  input  logic               start,
  input  logic               key_valid,
  input  logic [LW-1:0]      key_lane,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [4:0]         speed,
  output logic [1:0]         lives,
  output logic               pix_tile,
  output logic               pix_hit,
  output logic               pix_grid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;
  localparam int OW = $clog2(ROW_H + 32);
  localparam int RW = $clog2(SPEED_STEP_ROWS + 1);
  localparam int LB = $clog2(LANE_W);

`ifdef TILES_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif
  // Without the lives feature the counter never leaves zero.
  localparam logic [1:0] LIVES_RST = LIVES_EN ? 2'(LIVES_INIT) : 2'd0;

  logic [1:0]         state_r;
  logic [SCORE_W-1:0] score_r;
  logic [4:0]         speed_r;
  logic [1:0]         lives_r;
  logic [OW-1:0]      offset_r;
  logic [RW-1:0]      ramp_r;
  logic [7:0]         lfsr_r;
  logic               vs_q;
  logic [LW-1:0]      ent_lane [0:ROWS];
  logic               ent_hit  [0:ROWS];

  logic          tick, shift, hit_now, key_wrong, miss, err, fatal;
  logic [OW-1:0] off_nxt;
  logic [5:0]    spd_inc;
  logic [7:0]    lfsr_nxt;
  logic [LW-1:0] new_lane;

  assign tick      = vs & ~vs_q;
  assign off_nxt   = offset_r + OW'(speed_r);
  assign shift     = tick && (off_nxt >= OW'(ROW_H));
  assign hit_now   = key_valid && (key_lane == ent_lane[ROWS]) && !ent_hit[ROWS];
  assign key_wrong = key_valid && (key_lane != ent_lane[ROWS]);
  // A correct key landing on the shift cycle rescues the departing row.
  assign miss      = shift && !(ent_hit[ROWS] || hit_now);
  assign err       = key_wrong || miss;
  assign fatal     = err && (!LIVES_EN || (lives_r == 2'd1));
  assign spd_inc   = {1'b0, speed_r} + 6'(SPEED_INC);
  assign lfsr_nxt  = {1'b0, lfsr_r[7:1]} ^ (lfsr_r[0] ? 8'hB8 : 8'h00);
  assign new_lane  = LW'(lfsr_r % 8'(LANES));

  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      state_r  <= S_IDLE;
      score_r  <= '0;
      speed_r  <= '0;
      lives_r  <= LIVES_RST;
      offset_r <= '0;
      ramp_r   <= '0;
      lfsr_r   <= LFSR_SEED;
      vs_q     <= 1'b0;
      for (int r = 0; r <= ROWS; r++) begin
        ent_lane[r] <= LW'(r % LANES);
        ent_hit[r]  <= 1'b0;
      end
    end else begin
      vs_q   <= vs;
      lfsr_r <= lfsr_nxt;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_RUN;
            speed_r <= 5'(SPEED_INIT);
          end
        end
        S_RUN: begin
          if (fatal) begin
            state_r <= S_OVER;
            speed_r <= '0;
            lives_r <= '0;
          end else begin
            if (err) lives_r <= lives_r - 2'd1;
            if (hit_now) begin
              ent_hit[ROWS] <= 1'b1;
              if (score_r != '1) score_r <= score_r + SCORE_W'(1);
            end
            // The shift is written after the hit so a just-hit bottom row departs.
            if (shift) begin
              offset_r <= off_nxt - OW'(ROW_H);
              for (int r = ROWS; r >= 1; r--) begin
                ent_lane[r] <= ent_lane[r-1];
                ent_hit[r]  <= ent_hit[r-1];
              end
              ent_lane[0] <= new_lane;
              ent_hit[0]  <= 1'b0;
              if (ramp_r == RW'(SPEED_STEP_ROWS - 1)) begin
                ramp_r  <= '0;
                speed_r <= (spd_inc > 6'(SPEED_MAX)) ? 5'(SPEED_MAX) : spd_inc[4:0];
              end else begin
                ramp_r <= ramp_r + RW'(1);
              end
            end else if (tick) begin
              offset_r <= off_nxt;
            end
          end
        end
        S_OVER: begin
          if (start) begin
            state_r  <= S_IDLE;
            score_r  <= '0;
            lives_r  <= LIVES_RST;
            offset_r <= '0;
            ramp_r   <= '0;
            for (int r = 0; r <= ROWS; r++) begin
              ent_lane[r] <= LW'(r % LANES);
              ent_hit[r]  <= 1'b0;
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  logic [9:0]    col;
  logic [10:0]   ys, row_idx;
  logic [LW-1:0] sel_lane;
  logic          sel_hit, sel_ok, lane_ok, on_lane, edge_x;

  assign col     = DrawX >> LB;
  assign ys      = {1'b0, DrawY} + 11'(ROW_H) - 11'(offset_r);
  assign row_idx = ys / 11'(ROW_H);
  assign lane_ok = col < 10'(LANES);
  assign edge_x  = (DrawX[LB-1:0] == '0) || (DrawX[LB-1:0] == '1);

  always_comb begin
    sel_lane = '0;
    sel_hit  = 1'b0;
    sel_ok   = 1'b0;
    for (int i = 0; i <= ROWS; i++) begin
      if (row_idx == 11'(i)) begin
        sel_lane = ent_lane[i];
        sel_hit  = ent_hit[i];
        sel_ok   = 1'b1;
      end
    end
  end

  assign on_lane = sel_ok && lane_ok && (10'(sel_lane) == col);

  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      pix_tile <= 1'b0;
      pix_hit  <= 1'b0;
      pix_grid <= 1'b0;
    end else begin
      pix_tile <= on_lane && !sel_hit;
      pix_hit  <= on_lane && sel_hit;
      pix_grid <= edge_x && lane_ok;
    end
  end

  assign state = state_r;
  assign score = score_r;
  assign speed = speed_r;
  assign lives = lives_r;

endmodule
